add8_rr_sched: RTL and testbench

ADD8_RR_SCHED -- requirements
Module: add8_rr_sched

---
 rtl/add8_sched_pkg.sv | 29 ++
 rtl/add8_rr_sched_if.sv | 31 +++
 rtl/add8_lib.sv | 10 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/add8_rr_sched.sv | 104 ++++++++++
 tb/tb_add8_rr_sched.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/add8_sched_pkg.sv
// Shared parameters, id-width helper and pipeline stage records for add8_rr_sched.
package add8_sched_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned CNTW_DEF = 16;
  // Stage records carry a fixed-width id; users truncate to id_width(NREQ).
  localparam int unsigned ID_MAXW  = 8;

  // Requester index width; never zero so a single requester still has an id bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // S1: granted operands waiting for the shared adder.
  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
    logic [7:0]         a;
    logic [7:0]         b;
  } s1_t;

  // S2: adder result waiting for the consumer.
  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
    logic [8:0]         sum;
  } s2_t;

endpackage

// File: rtl/add8_rr_sched_if.sv
// Requester-side and consumer-side handshake bundle of the shared adder.
interface add8_rr_sched_if
  import add8_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
);

  localparam int unsigned IDW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_sum;

  // Environment side: issues requests and consumes results.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );

endinterface

// File: rtl/add8_lib.sv
// Library 8-bit adder core; the scheduler passes its output through untouched.
module add8_lib (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] O
);

  assign O = 9'(A) + 9'(B);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins, one-hot grant.
module rr_arbiter
  import add8_sched_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Search [ptr..NREQ-1] first, then fall back to the lowest index below ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add8_rr_sched.sv
// Round-robin scheduler feeding NREQ requesters through one shared 8-bit adder (2-stage pipe).
module add8_rr_sched
  import add8_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  add8_rr_sched_if.slave  bus,
  output logic [CNTW-1:0] op_count
);

  localparam int unsigned IDW = id_width(NREQ);

  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready_c;
  logic [IDW-1:0]  win_id;
  logic [7:0]      win_a, win_b;
  logic [8:0]      core_sum;
  logic            s2_adv, s1_load, xfer, rsp_fire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  add8_lib u_add (
    .A (s1_q.a),
    .B (s1_q.b),
    .O (core_sum)
  );

  // Occupancy/handshake: S2 moves when empty or drained; S1 refills when empty or moving.
  always_comb begin
    s2_adv   = !s2_q.valid || bus.rsp_ready;
    s1_load  = rst_n && (!s1_q.valid || s2_adv);
    ready_c  = s1_load ? grant : '0;
    xfer     = |(bus.req_valid & ready_c);
    rsp_fire = s2_q.valid && bus.rsp_ready;
  end

  // Winner index and its operands out of the packed request buses.
  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id = IDW'(i);
        win_a  = bus.req_a[8*i +: 8];
        win_b  = bus.req_b[8*i +: 8];
      end
    end
  end

  // Next state for pointer and both pipeline stages.
  always_comb begin
    ptr_d = ptr_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    if (xfer) begin
      ptr_d = (32'(win_id) == NREQ - 1) ? '0 : IDW'(32'(win_id) + 1);
    end
    if (s2_adv) begin
      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.sum   = core_sum;
    end
    if (s1_load) begin
      s1_d.valid = xfer;
      s1_d.id    = ID_MAXW'(win_id);
      s1_d.a     = win_a;
      s1_d.b     = win_b;
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      op_count <= '0;
    end else begin
      ptr_q <= ptr_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      if (rsp_fire) begin
        op_count <= op_count + CNTW'(1);
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = s2_q.valid;
  assign bus.rsp_id    = IDW'(s2_q.id);
  assign bus.rsp_sum   = s2_q.sum;

endmodule

// File: tb/tb_add8_rr_sched.sv
// Self-checking bench for add8_rr_sched: arbitration table, corner sequences, scoreboarded random run.
module tb_add8_rr_sched;
  import add8_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CNTW = 4;
  localparam int unsigned IDW  = id_width(NREQ);

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CNTW-1:0] op_count;

  add8_rr_sched_if #(.NREQ(NREQ)) bus ();

  add8_rr_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [8:0]     sum;
  } exp_t;

  typedef struct packed {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] g;
  } vec_t;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  logic [CNTW-1:0] cnt_model = '0;
  logic            hold_q = 1'b0;
  logic [IDW-1:0]  hold_id = '0;
  logic [8:0]      hold_sum = '0;
  vec_t            tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    bus.req_a = {$urandom, $urandom};
    bus.req_b = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: transfers seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      cnt_model = '0;
      hold_q    = 1'b0;
    end else begin
      check("req_ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      check("req_ready_subset", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
      check("op_count", 32'(op_count), 32'(cnt_model));
      if (hold_q) begin
        check("hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("hold_id", 32'(bus.rsp_id), 32'(hold_id));
        check("hold_sum", 32'(bus.rsp_sum), 32'(hold_sum));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
        end
        cnt_model = cnt_model + CNTW'(1);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back('{IDW'(i), 9'(bus.req_a[8*i +: 8]) + 9'(bus.req_b[8*i +: 8])});
        end
      end
      hold_q   = bus.rsp_valid && !bus.rsp_ready;
      hold_id  = bus.rsp_id;
      hold_sum = bus.rsp_sum;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // Arbitration table starting from pointer 0 with the consumer always ready.
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b0110, 4'b0010};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b1001, 4'b1000};
    tbl[7]  = '{4'b1001, 4'b0001};
    tbl[8]  = '{4'b0001, 4'b0001};
    tbl[9]  = '{4'b1000, 4'b1000};
    tbl[10] = '{4'b0100, 4'b0100};
    tbl[11] = '{4'b1001, 4'b1000};
    tbl[12] = '{4'b1001, 4'b0001};

    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset values while held, requests pending.
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    step();
    step();
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Single operation: latency and result.
    bus.req_valid = 4'b0001;
    bus.req_a     = 32'h0000_0010;
    bus.req_b     = 32'h0000_0022;
    #1 check("single_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    check("single_s1_only", 32'(bus.rsp_valid), 32'd0);
    step();
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("single_rsp_sum", 32'(bus.rsp_sum), 32'h032);
    step();
    check("single_op_count", 32'(op_count), 32'd1);
    check("single_idle", 32'(bus.rsp_valid), 32'd0);

    // Round-robin table, including pointer wrap 3 -> 0.
    apply_reset();
    for (int r = 0; r < 13; r++) begin
      bus.req_valid = tbl[r].v;
      rand_ops();
      #1 check($sformatf("tbl_grant_%0d", r), 32'(bus.req_ready), 32'(tbl[r].g));
      step();
    end
    drain("tbl_drain");

    // Backpressure with requester 1 pending.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_a     = 32'h0000_FE00;
    bus.req_b     = 32'h0000_0200;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
      check("bp_rsp_sum", 32'(bus.rsp_sum), 32'h100);
      step();
    end
    drain("bp_drain");

    // Reset with both stages full.
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    rand_ops();
    step();
    step();
    check("full_before_rst", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("midrst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Seventeen results wrap a 4-bit counter to 1.
    bus.req_valid = '1;
    for (int c = 0; c < 17; c++) begin
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    step();
    step();
    step();
    check("cnt_wrap", 32'(op_count), 32'd1);

    // Random traffic with random backpressure and request withdrawal.
    for (int c = 0; c < 300; c++) begin
      bus.req_valid = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
